md_seq_ctrl: RTL and testbench
==============================

Name: md_seq_ctrl

Overview:
- Sequencer for the multi-cycle multiply/divide unit and its HI/LO registers in the 5-stage MIPS pipeline.
- It accepts an operation issued from the E stage and models the unit's fixed latency with a down-counter.
- While the operation runs it asserts Busy, and it stalls any D-stage multiply/divide/HI/LO instruction until the result is committed.
- Its Stall output is ORed with the hazard-unit stall at the pipeline controller.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for MULT/MULTU (range 1..15)
- DIV_CYCLES, 10, cycles Busy stays high for DIV/DIVU (range 1..15)

Ports:
- Clk  in  1  clock; all state changes on its rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  E-stage instruction is a valid md operation this cycle
- Md_op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; others are treated as none
- Rs_val  in  32  forwarded rs operand (E stage)
- Rt_val  in  32  forwarded rt operand (E stage)
- D_is_md  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- Busy  out  1  operation in progress
- Stall  out  1  stall request to the D stage
- Hi  out  32  HI register
- Lo  out  32  LO register

Behaviour:
- Reset (Reset=0, asynchronous)
  - State goes to IDLE; counter=0; Hi=0; Lo=0; Busy=0.
  - Any in-flight operation is discarded.
- States
  - IDLE, RUN.
  - Busy = (state==RUN), registered.
  - Stall = D_is_md & (Start_mul_div | Busy), combinational. Start_mul_div means Start=1 with Md_op in 001..100.
- IDLE with Start=1 and a mul/div op (issue in cycle t)
  - Latch the result at the edge ending cycle t:
    - MULT: signed 64-bit product.
    - MULTU: unsigned 64-bit product.
    - DIV/DIVU: quotient and remainder, signed or unsigned.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - Busy=1 during cycles t+1..t+N.
- RUN
  - Counter decrements each cycle.
  - At the edge ending cycle t+N (counter==1): Hi/Lo take the latched result and the state returns to IDLE.
  - Busy=0 from cycle t+N+1; the committed Hi/Lo are visible from then.
- Result mapping
  - Multiply: Hi=product[63:32], Lo=product[31:0].
  - Divide: Lo=quotient, Hi=remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (Rt_val==0)
  - The full latency still elapses.
  - Hi/Lo are left unchanged at commit.
- DIV of 0x80000000 by 0xFFFFFFFF: Lo=0x80000000, Hi=0.
- MTHI/MTLO with Start=1
  - Valid only in IDLE.
  - Hi (or Lo) = Rs_val at the edge ending cycle t.
  - No Busy, no counter load.
- Start=1 while RUN
  - Ignored: no restart, no HI/LO write. The pipeline never produces this because of Stall.
  - Verification asserts it never occurs.
- Start=1 with Md_op=000 or 111: no effect.
- MFHI/MFLO are read combinationally from Hi/Lo by the datapath. The block gives them no special handling beyond Stall.

Optional Feature:
- Macro: MD_SEQ_CANCEL_EN.
- Enabled:
  - Adds input Cancel (1 bit); the E-stage flush drives it.
  - Cancel=1 in RUN: at the next edge return to IDLE, clear the counter, discard the latched result, leave Hi/Lo untouched.
  - Cancel=1 in the same cycle as Start suppresses the issue, including MTHI/MTLO writes.
- Disabled:
  - The port is absent.
  - Operations always run to completion.

Test Plan:
- Reset low mid-RUN (3 cycles into DIV): Busy=0, Hi=0, Lo=0 immediately; after release, IDLE and Stall=0.
- MULT Rs=0xFFFFFFFE (-2), Rt=3: Busy high for exactly 5 cycles, then Hi=0xFFFFFFFF, Lo=0xFFFFFFFA. MULTU with the same operands gives Hi=0x00000002, Lo=0xFFFFFFFA.
- DIV Rs=-7 (0xFFFFFFF9), Rt=2: Busy for 10 cycles, then Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 7/0 afterwards leaves Hi/Lo unchanged after 10 cycles.
- MULT issued with D_is_md=1 held: Stall=1 in the issue cycle and all 5 Busy cycles, Stall=0 in the next cycle. With D_is_md=0, Stall stays 0 throughout.
- MTHI Rs=0x12345678, then MTLO Rs=0x9ABCDEF0 on the next cycle: Hi/Lo updated one edge after each, Busy never asserted.
- With MD_SEQ_CANCEL_EN: MULT issued with Hi=Lo=0x11111111 beforehand, Cancel pulsed in Busy cycle 2. Busy drops the next cycle and Hi/Lo stay 0x11111111; a new DIV issued afterwards completes normally.

Source files
------------

// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl: multiply/divide sequencer with HI/LO registers.
// Define MD_SEQ_CANCEL_EN to add the Cancel (E-stage flush) input.
module md_seq_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Md_op,
    input  logic [31:0] Rs_val,
    input  logic [31:0] Rt_val,
    input  logic        D_is_md,
`ifdef MD_SEQ_CANCEL_EN
    input  logic        Cancel,
`endif
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] res_hi_q, res_lo_q;
    logic        res_ok_q;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        cancel_w;
    logic        is_mul, is_div, start_md;
    logic        issue_md, commit, mthi_wr, mtlo_wr;
    logic [31:0] res_hi_d, res_lo_d;
    logic        res_ok_d;

`ifdef MD_SEQ_CANCEL_EN
    assign cancel_w = Cancel;
`else
    assign cancel_w = 1'b0;
`endif

    assign is_mul   = (Md_op == OP_MULT) | (Md_op == OP_MULTU);
    assign is_div   = (Md_op == OP_DIV) | (Md_op == OP_DIVU);
    assign start_md = Start & (is_mul | is_div);
    assign issue_md = start_md & ~cancel_w & (state_q == S_IDLE);

    // Arithmetic: result computed in the issue cycle, held until commit
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_den, q_mag, r_mag, quo, rem;

    always_comb begin
        prod_s = {{32{Rs_val[31]}}, Rs_val} * {{32{Rt_val[31]}}, Rt_val};
        prod_u = {32'd0, Rs_val} * {32'd0, Rt_val};
        // Divide on magnitudes so INT_MIN / -1 wraps deterministically
        a_neg  = (Md_op == OP_DIV) & Rs_val[31];
        b_neg  = (Md_op == OP_DIV) & Rt_val[31];
        a_mag  = a_neg ? (~Rs_val + 32'd1) : Rs_val;
        b_mag  = b_neg ? (~Rt_val + 32'd1) : Rt_val;
        b_den  = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_den;
        r_mag  = a_mag % b_den;
        quo    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
        res_hi_d = rem;
        res_lo_d = quo;
        res_ok_d = (Rt_val != 32'd0);
        if (Md_op == OP_MULT) begin
            res_hi_d = prod_s[63:32];
            res_lo_d = prod_s[31:0];
            res_ok_d = 1'b1;
        end else if (Md_op == OP_MULTU) begin
            res_hi_d = prod_u[63:32];
            res_lo_d = prod_u[31:0];
            res_ok_d = 1'b1;
        end
    end

    // FSM state and latency counter register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: load counter on issue, count down while running
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (issue_md) begin
                    state_d = S_RUN;
                    cnt_d   = is_mul ? MULT_N : DIV_N;
                end
            end
            S_RUN: begin
                if (cancel_w || cnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // FSM outputs: busy/stall and register write strobes
    always_comb begin
        Busy    = (state_q == S_RUN);
        Stall   = D_is_md & (start_md | Busy);
        commit  = Busy & (cnt_q == 4'd1) & ~cancel_w;
        mthi_wr = Start & ~cancel_w & ~Busy & (Md_op == OP_MTHI);
        mtlo_wr = Start & ~cancel_w & ~Busy & (Md_op == OP_MTLO);
    end

    // HI/LO next value: commit of a valid result, or a direct move
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit && res_ok_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
        end
        if (mthi_wr) hi_d = Rs_val;
        if (mtlo_wr) lo_d = Rs_val;
    end

    // Latched result and architectural HI/LO registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            res_ok_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            if (issue_md) begin
                res_hi_q <= res_hi_d;
                res_lo_q <= res_lo_d;
                res_ok_q <= res_ok_d;
            end else if (Busy && cancel_w) begin
                res_ok_q <= 1'b0;
            end
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign Hi = hi_q;
    assign Lo = lo_q;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Scoreboard bench for md_seq_ctrl: driver pushes expected results,
// monitor pops and compares on each commit / register move.
module tb_md_seq_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  Md_op = 3'd0;
    logic [31:0] Rs_val = 32'd0;
    logic [31:0] Rt_val = 32'd0;
    logic        D_is_md = 1'b0;
`ifdef MD_SEQ_CANCEL_EN
    logic        Cancel = 1'b0;
`endif
    logic        Busy, Stall;
    logic [31:0] Hi, Lo;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          kind;
        int          n;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dmd;
        logic [2:0]  op;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        mon_busy = 1'b0;

    md_seq_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .Md_op(Md_op),
        .Rs_val(Rs_val),
        .Rt_val(Rt_val),
        .D_is_md(D_is_md),
`ifdef MD_SEQ_CANCEL_EN
        .Cancel(Cancel),
`endif
        .Busy(Busy),
        .Stall(Stall),
        .Hi(Hi),
        .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    task automatic check32(input string nm, input logic [31:0] act,
                           input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: architectural result of an op on the given HI/LO
    function automatic void model(input logic [2:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  inout logic [31:0] hi,
                                  inout logic [31:0] lo);
        longint          sp, x, y;
        longint unsigned up;
        case (op)
            3'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                hi = sp[63:32];
                lo = sp[31:0];
            end
            3'd2: begin
                up = 64'(a) * 64'(b);
                hi = up[63:32];
                lo = up[31:0];
            end
            3'd3: if (b != 0) begin
                x  = longint'($signed(a));
                y  = longint'($signed(b));
                sp = x / y;
                lo = sp[31:0];
                sp = x % y;
                hi = sp[31:0];
            end
            3'd4: if (b != 0) begin
                lo = a / b;
                hi = a % b;
            end
            3'd5: hi = a;
            3'd6: lo = a;
            default: ;
        endcase
    endfunction

    // Called just after a falling edge; returns just after one
    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic dmd,
                         input int cancel_at);
        exp_t e;
        bit   md;
        int   k;
        md = (op >= 3'd1 && op <= 3'd4);
        Start = 1'b1; Md_op = op; Rs_val = a; Rt_val = b;
        D_is_md = dmd;
        if (cancel_at == 0) model(op, a, b, m_hi, m_lo);
        e.kind = md ? 1 : 0;
        e.n    = (cancel_at > 0) ? cancel_at :
                 ((op <= 3'd2) ? 5 : 10);
        e.hi   = m_hi;
        e.lo   = m_lo;
        e.dmd  = dmd;
        e.op   = op;
        sbq.push_back(e);
        #1;
        check32("stall_issue", {31'd0, Stall}, {31'd0, dmd & md});
        @(negedge Clk);
        Start = 1'b0; Md_op = 3'd0;
        if (md) begin
            k = 1;
            while (Busy && k < 30) begin
`ifdef MD_SEQ_CANCEL_EN
                Cancel = (k == cancel_at);
`endif
                @(negedge Clk);
                k++;
            end
`ifdef MD_SEQ_CANCEL_EN
            Cancel = 1'b0;
`endif
            @(negedge Clk);
        end
        D_is_md = 1'b0;
    endtask

    // Monitor: pop at the issue edge, compare once the result is visible
    initial begin
        exp_t e;
        int   cnt;
        forever begin
            @(posedge Clk);
            if (sbq.size() > 0) begin
                mon_busy = 1'b1;
                e = sbq.pop_front();
                @(negedge Clk);
                if (e.kind == 1) begin
                    cnt = 0;
                    while (Busy && cnt < 30) begin
                        check32("stall_busy", {31'd0, Stall},
                                {31'd0, e.dmd});
                        cnt++;
                        @(negedge Clk);
                    end
                    check32("busy_len", 32'(cnt), 32'(e.n));
                    check32("stall_after", {31'd0, Stall}, 32'd0);
                end else begin
                    check32("busy_mt", {31'd0, Busy}, 32'd0);
                end
                check32($sformatf("hi_op%0d", e.op), Hi, e.hi);
                check32($sformatf("lo_op%0d", e.op), Lo, e.lo);
                mon_busy = 1'b0;
            end
        end
    end

    // Protocol: the pipeline never issues into a running unit
    always @(negedge Clk) begin
        if (Reset && Busy && Start && Md_op >= 3'd1 && Md_op <= 3'd6) begin
            total++;
            bad++;
            $display("FAIL start_in_run: op %0d while busy", Md_op);
        end
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          w;
        repeat (2) @(negedge Clk);
        #1;
        check32("rst_busy", {31'd0, Busy}, 32'd0);
        check32("rst_hi", Hi, 32'd0);
        check32("rst_lo", Lo, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);

        do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 0);
        do_op(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 0);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        do_op(3'd4, 32'd7, 32'd0, 1'b0, 0);
        do_op(3'd5, 32'h1234_5678, 32'd0, 1'b1, 0);
        do_op(3'd6, 32'h9ABC_DEF0, 32'd0, 1'b0, 0);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(3'd0, 32'hDEAD_BEEF, 32'd1, 1'b1, 0);
        do_op(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b1, 0);

        // Reset three cycles into a DIV; not tracked by the scoreboard
        Start = 1'b1; Md_op = 3'd3; Rs_val = 32'd100; Rt_val = 32'd7;
        @(negedge Clk);
        Start = 1'b0; Md_op = 3'd0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        #1;
        check32("midrun_busy", {31'd0, Busy}, 32'd0);
        check32("midrun_hi", Hi, 32'd0);
        check32("midrun_lo", Lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge Clk);
        Reset = 1'b1;
        D_is_md = 1'b1;
        #1;
        check32("post_rst_stall", {31'd0, Stall}, 32'd0);
        check32("post_rst_busy", {31'd0, Busy}, 32'd0);
        @(negedge Clk);
        D_is_md = 1'b0;

`ifdef MD_SEQ_CANCEL_EN
        do_op(3'd5, 32'h1111_1111, 32'd0, 1'b0, 0);
        do_op(3'd6, 32'h1111_1111, 32'd0, 1'b0, 0);
        do_op(3'd1, 32'd1234, 32'd5678, 1'b1, 2);
        do_op(3'd3, 32'd100, 32'd7, 1'b0, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            do_op(op, a, b, 1'($urandom_range(0, 1)), 0);
        end

        w = 0;
        while ((sbq.size() > 0 || mon_busy) && w < 50) begin
            @(negedge Clk);
            w++;
        end
        if (sbq.size() > 0 || mon_busy) begin
            total++;
            bad++;
            $display("FAIL drain: %0d pending want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
